// File: rtl/controlador_es_pkg.sv
// Shared types and constants for the I/O controller: FSM encoding and
// 7-segment font (active-high, bit 0 = segment a .. bit 6 = segment g).
package controlador_es_pkg;

    typedef enum logic [1:0] {
        EXECUTA        = 2'd0,
        ESPERA_ENTRADA = 2'd1,
        LIBERA         = 2'd2,
        HALT           = 2'd3
    } estado_t;

    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/decodificador_7seg.sv
// Hex nibble to active-low 7-segment pattern.
module decodificador_7seg
    import controlador_es_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = ~SEG_HEX[hex_i];

endmodule

// File: rtl/controlador_es.sv
// Processor I/O controller: stalls the CPU on IN until a debounced button
// press latches the switches, captures OUT values and drives four hex digits.
module controlador_es
    import controlador_es_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        OpIn,
    input  logic        OpOut,
    input  logic        OpHalt,
    input  logic [27:0] display_in,
    input  logic [17:0] switches_in,
    input  logic        botao_n,
    output logic        cpu_enable,
    output logic [17:0] switches_out,
    output logic [27:0] valor_out,
    output logic [27:0] seg_n,
    output logic        led_espera,
    output logic        led_halt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press;
    estado_t       estado_q, estado_d;
    logic [17:0]   sw_q, sw_d;
    logic [27:0]   valor_q, valor_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Pulse on the debounced 1->0 edge only, so a held button fires once.
    assign press = deb_prev_q & ~deb_q;

    always_comb begin
        estado_d   = estado_q;
        sw_d       = sw_q;
        valor_d    = valor_q;
        cpu_enable = 1'b0;
        case (estado_q)
            EXECUTA: begin
                cpu_enable = ~OpIn & ~OpHalt;
                if (OpOut && !OpHalt) valor_d = display_in;
                if (OpHalt)    estado_d = HALT;
                else if (OpIn) estado_d = ESPERA_ENTRADA;
            end
            ESPERA_ENTRADA: begin
                if (press) begin
                    sw_d     = switches_in;
                    estado_d = LIBERA;
                end
            end
            LIBERA: begin
                cpu_enable = 1'b1;
                estado_d   = EXECUTA;
            end
            default: estado_d = HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            estado_q   <= EXECUTA;
            sw_q       <= '0;
            valor_q    <= '0;
        end else begin
            sync1_q    <= botao_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            estado_q   <= estado_d;
            sw_q       <= sw_d;
            valor_q    <= valor_d;
        end
    end

    assign switches_out = sw_q;
    assign valor_out    = valor_q;
    assign led_espera   = (estado_q == ESPERA_ENTRADA);
    assign led_halt     = (estado_q == HALT);

    for (genvar i = 0; i < 4; i++) begin : g_dig
        decodificador_7seg u_dec (
            .hex_i  (valor_q[4*i +: 4]),
            .seg_n_o(seg_n[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_controlador_es.sv
// Randomized self-checking bench for controlador_es with a cycle-level
// behavioural model and an independent segment font.
module tb_controlador_es;

    localparam int DEB = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        OpIn = 1'b0, OpOut = 1'b0, OpHalt = 1'b0, botao_n = 1'b1;
    logic [27:0] display_in = '0;
    logic [17:0] switches_in = '0;
    logic        cpu_enable, led_espera, led_halt;
    logic [17:0] switches_out;
    logic [27:0] valor_out, seg_n;

    controlador_es #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock), .reset_n(reset_n), .OpIn(OpIn), .OpOut(OpOut), .OpHalt(OpHalt),
        .display_in(display_in), .switches_in(switches_in), .botao_n(botao_n),
        .cpu_enable(cpu_enable), .switches_out(switches_out), .valor_out(valor_out),
        .seg_n(seg_n), .led_espera(led_espera), .led_halt(led_halt)
    );

    always #5 clock = ~clock;

    wire [76:0] dut_v = {cpu_enable, led_espera, led_halt, switches_out, valor_out, seg_n};

    int n_vec = 0, n_err = 0;

    // Model: 0 = executing, 1 = waiting for confirm, 2 = release, 3 = halted
    int          m_state, m_run;
    bit          m_s1, m_s2, m_deb, m_deb_prev;
    logic [17:0] m_sw;
    logic [27:0] m_val;

    function automatic logic [6:0] font(input logic [3:0] d);
        string s;
        logic [6:0] m = '0;
        case (d)
            4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";   4'h3: s = "abcdg";
            4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg";  4'h7: s = "abc";
            4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg";  4'hB: s = "cdefg";
            4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";   default: s = "aefg";
        endcase
        for (int k = 0; k < s.len(); k++) m[s[k] - "a"] = 1'b1;
        return m;
    endfunction

    function automatic logic [76:0] expv();
        logic cpu;
        logic [27:0] sg;
        cpu = (m_state == 2) || (m_state == 0 && !OpIn && !OpHalt);
        for (int k = 0; k < 4; k++) sg[7*k +: 7] = ~font(m_val[4*k +: 4]);
        return {cpu, m_state == 1, m_state == 3, m_sw, m_val, sg};
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0;
        m_s1 = 1; m_s2 = 1; m_deb = 1; m_deb_prev = 1;
        m_sw = '0; m_val = '0;
    endtask

    // One clock edge: next model state from the inputs held during this cycle.
    task automatic tick();
        int ns;
        bit press, raw;
        logic [17:0] nsw;
        logic [27:0] nval;
        press = m_deb_prev && !m_deb;
        raw = botao_n; ns = m_state; nsw = m_sw; nval = m_val;
        case (m_state)
            0: begin
                if (OpOut && !OpHalt) nval = display_in;
                if (OpHalt) ns = 3; else if (OpIn) ns = 1;
            end
            1: if (press) begin nsw = switches_in; ns = 2; end
            2: ns = 0;
            default: ns = 3;
        endcase
        @(posedge clock);
        m_deb_prev = m_deb;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin m_deb = m_s2; m_run = 0; end
        end else m_run = 0;
        m_s2 = m_s1; m_s1 = raw;
        m_state = ns; m_sw = nsw; m_val = nval;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; model_reset();
        #2;
        if (dut_v !== expv()) begin n_err++; $display("FAIL reset_async: dut=%h model=%h", dut_v, expv()); end
        n_vec++;
        if (seg_n !== {4{7'h40}}) begin n_err++; $display("FAIL reset_seg0000: got %h want %h", seg_n, {4{7'h40}}); end
        n_vec++;
        @(negedge clock); reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dut_v !== expv()) begin n_err++; $display("FAIL reset_idle%0d: dut=%h model=%h", i, dut_v, expv()); end
            n_vec++;
        end
    endtask

    task automatic test_out();
        OpOut = 1; display_in = 28'h000BEEF; #1;
        if (cpu_enable !== 1'b1) begin n_err++; $display("FAIL out_cpu_en: got %b want 1", cpu_enable); end
        n_vec++;
        tick(); OpOut = 0; display_in = 28'h1234567; #1;
        if (valor_out !== 28'h000BEEF) begin n_err++; $display("FAIL out_valor: got %h want 000beef", valor_out); end
        n_vec++;
        if (dut_v !== expv()) begin n_err++; $display("FAIL out_digits: dut=%h model=%h", dut_v, expv()); end
        n_vec++;
    endtask

    task automatic test_in();
        int lib = 0;
        OpIn = 1; switches_in = 18'h2A5A5; #1;
        if (cpu_enable !== 1'b0) begin n_err++; $display("FAIL in_stall: got %b want 0", cpu_enable); end
        n_vec++;
        tick();
        if (led_espera !== 1'b1) begin n_err++; $display("FAIL in_led_espera: got %b want 1", led_espera); end
        n_vec++;
        botao_n = 0;
        for (int i = 0; i < 14; i++) begin
            if (m_state == 0 && lib > 0) OpIn = 0;
            #1;
            if (dut_v !== expv()) begin n_err++; $display("FAIL in_cycle%0d: dut=%h model=%h", i, dut_v, expv()); end
            n_vec++;
            if (OpIn && cpu_enable && !led_espera && !led_halt) lib++;
            tick();
        end
        OpIn = 0;
        if (lib !== 1) begin n_err++; $display("FAIL in_libera_count: got %0d want 1", lib); end
        n_vec++;
        if (switches_out !== 18'h2A5A5 || led_espera !== 1'b0) begin
            n_err++; $display("FAIL in_latched: got sw=%h esp=%b want 2a5a5/0", switches_out, led_espera);
        end
        n_vec++;
        botao_n = 1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_glitch();
        OpIn = 1; switches_in = 18'h15555; tick(); OpIn = 0;
        botao_n = 0; tick(); tick(); botao_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dut_v !== expv()) begin n_err++; $display("FAIL glitch_cycle%0d: dut=%h model=%h", i, dut_v, expv()); end
            n_vec++;
        end
        if (led_espera !== 1'b1 || switches_out !== 18'h2A5A5) begin
            n_err++; $display("FAIL glitch_hold: got esp=%b sw=%h want 1/2a5a5", led_espera, switches_out);
        end
        n_vec++;
        botao_n = 0;
        for (int i = 0; i < 10; i++) tick();
        botao_n = 1;
        for (int i = 0; i < 8; i++) tick();
        if (dut_v !== expv()) begin n_err++; $display("FAIL glitch_exit: dut=%h model=%h", dut_v, expv()); end
        n_vec++;
    endtask

    task automatic test_held();
        OpIn = 1; switches_in = 18'h00F0F; tick(); OpIn = 0;
        botao_n = 0;
        for (int i = 0; i < 12; i++) tick();
        OpIn = 1; switches_in = 18'h3C3C3; tick(); OpIn = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) botao_n = 1;
            tick();
            if (dut_v !== expv()) begin n_err++; $display("FAIL held_cycle%0d: dut=%h model=%h", i, dut_v, expv()); end
            n_vec++;
        end
        if (led_espera !== 1'b1 || switches_out !== 18'h00F0F) begin
            n_err++; $display("FAIL held_no_press: got esp=%b sw=%h want 1/00f0f", led_espera, switches_out);
        end
        n_vec++;
        botao_n = 0;
        for (int i = 0; i < 10; i++) tick();
        if (switches_out !== 18'h3C3C3 || led_espera !== 1'b0) begin
            n_err++; $display("FAIL held_new_press: got sw=%h esp=%b want 3c3c3/0", switches_out, led_espera);
        end
        n_vec++;
        botao_n = 1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset_mid();
        OpIn = 1; tick(); OpIn = 0;
        botao_n = 0; tick(); tick(); tick();
        #2 reset_n = 0; model_reset(); #1;
        if (dut_v !== expv()) begin n_err++; $display("FAIL rstmid_async: dut=%h model=%h", dut_v, expv()); end
        n_vec++;
        botao_n = 1;
        @(negedge clock); reset_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dut_v !== expv()) begin n_err++; $display("FAIL rstmid_after%0d: dut=%h model=%h", i, dut_v, expv()); end
            n_vec++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) botao_n = ~botao_n;
            OpIn = ($urandom_range(5) == 0);
            OpOut = ($urandom_range(2) == 0);
            display_in = 28'($urandom);
            switches_in = 18'($urandom);
            #1;
            if (dut_v !== expv()) begin n_err++; $display("FAIL rand_cycle%0d: dut=%h model=%h", i, dut_v, expv()); end
            n_vec++;
            tick();
        end
        OpIn = 0; OpOut = 0; botao_n = 1;
        for (int i = 0; i < 30; i++) begin
            if (m_state == 1) botao_n = (i % 12) >= 6;
            tick();
        end
    endtask

    task automatic test_halt();
        if (m_state != 0) begin n_err++; $display("FAIL halt_precond: model state %0d want 0", m_state); end
        OpHalt = 1; OpIn = 1; #1;
        if (cpu_enable !== 1'b0) begin n_err++; $display("FAIL halt_stall: got %b want 0", cpu_enable); end
        n_vec++;
        tick(); OpHalt = 0; OpIn = 0;
        for (int i = 0; i < 30; i++) begin
            botao_n = (i % 10) >= 5;
            OpOut = 1; display_in = 28'($urandom);
            #1;
            if (dut_v !== expv() || led_halt !== 1'b1 || cpu_enable !== 1'b0) begin
                n_err++; $display("FAIL halt_cycle%0d: dut=%h model=%h", i, dut_v, expv());
            end
            n_vec++;
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_out();
        test_in();
        test_glitch();
        test_held();
        test_reset_mid();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_es.md
CONTROLADOR_ES -- requirements
Module: controlador_es

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive cycles the synchronized button level must hold before the debounced level changes.
REQ-002 clock  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 OpIn  in  1  processor IN instruction indication.
REQ-005 OpOut  in  1  processor OUT instruction indication.
REQ-006 OpHalt  in  1  processor HALT instruction indication.
REQ-007 display_in  in  28  processor output bus, valid when OpOut=1.
REQ-008 switches_in  in  18  raw board switches.
REQ-009 botao_n  in  1  raw confirm pushbutton, asynchronous; 0 = pressed.
REQ-010 cpu_enable  out  1  processor clock enable; 1 = processor advances this cycle.
REQ-011 switches_out  out  18  latched switch value delivered to the processor.
REQ-012 valor_out  out  28  last value written by OUT.
REQ-013 seg_n  out  28  four 7-segment digits, active-low; digit i is seg_n[7i+6:7i].
REQ-014 led_espera  out  1  1 while waiting for confirm press.
REQ-015 led_halt  out  1  1 while halted.

Function
REQ-016 botao_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Debounce: counter SHALL clear when synchronized level equals debounced level; otherwise it SHALL increment, and at DEBOUNCE_CYCLES-1 the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-018 press SHALL be a one-cycle pulse on the debounced released-to-pressed transition; holding the button SHALL NOT produce further pulses.
REQ-019 FSM states: EXECUTA, ESPERA_ENTRADA, LIBERA, HALT.
REQ-020 EXECUTA: if OpHalt=1, next state is HALT; else if OpIn=1, next state is ESPERA_ENTRADA; else the state is unchanged. Priority is OpHalt > OpIn > OpOut.
REQ-021 ESPERA_ENTRADA: on press, switches_out SHALL load switches_in and the next state is LIBERA; otherwise the state holds. A press already debounced before entry SHALL NOT count.
REQ-022 LIBERA SHALL last exactly one cycle, then go to EXECUTA; OpIn=1 during LIBERA SHALL NOT re-enter ESPERA_ENTRADA.
REQ-023 HALT is absorbing until reset_n=0.
REQ-024 cpu_enable SHALL be combinational: 1 in LIBERA, or in EXECUTA with OpIn=0 and OpHalt=0; 0 otherwise (same-cycle stall, no skid).
REQ-025 When in EXECUTA with OpOut=1 and OpHalt=0, valor_out SHALL load display_in at that edge (zero stall).
REQ-026 seg_n digit i SHALL be the hex decode (0-F) of valor_out[4i+3:4i], i=0..3; segment order a..g = bit 0..6.
REQ-027 led_espera SHALL equal (state==ESPERA_ENTRADA); led_halt SHALL equal (state==HALT).
REQ-028 switches_out SHALL change only per REQ-021.

Reset
REQ-029 Asserting reset_n=0 at any time, including mid-wait or mid-debounce, SHALL immediately force: state EXECUTA, switches_out 0, valor_out 0, synchronizer flops 1, debounced level released, counter 0.
REQ-030 Consequently, immediately after reset: cpu_enable follows REQ-024, and seg_n shows "0000".

Structure
REQ-031 FSM state encoding and the segment lookup constants SHALL reside in the shared package controlador_es_pkg.
REQ-032 The hex-to-7-segment decode SHALL be one combinational sub-module, decodificador_7seg, instantiated four times.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset, then OpOut=1 with display_in=28'h000BEEF for one cycle -> valor_out=28'h000BEEF next cycle; seg_n digits decode F,E,E,B; cpu_enable=1 throughout.
REQ-034 OpIn=1 held, switches_in=18'h2A5A5 -> cpu_enable=0 the same cycle; led_espera=1. Then botao_n=0 held for 8 cycles -> switches_out=18'h2A5A5 and exactly one LIBERA cycle with cpu_enable=1, then EXECUTA.
REQ-035 During ESPERA_ENTRADA, botao_n glitches low for 2 cycles -> no press; state and switches_out unchanged.
REQ-036 Button still held from a previous IN when the next OpIn arrives -> stays in ESPERA_ENTRADA until release and a new press.
REQ-037 OpHalt=1 together with OpIn=1 -> HALT; cpu_enable=0 and led_halt=1 forever; a later press has no effect.
REQ-038 Pulse reset_n=0 while in ESPERA_ENTRADA with the debounce counter nonzero -> all REQ-029 values asynchronously; state EXECUTA.
